proc_mem_requester: RTL
=======================

// Module: proc_mem_requester
// PURPOSE
//  Processor-side initiator for memory_subsystem: one instance per core (PROC_ID 0..3).
//  Accepts core loads/stores, holds a small direct-mapped write-back cache with per-line
//  I/S/M state, and issues proc_req + read/write requests to the shared memory subsystem.
//  Drives one processor_N_req line; consumes the matching processor_N_resp data.
// PARAMETERS
//  DATA_SIZE  2   bytes per word; data width = DATA_SIZE*8
//  ADDR_W     14  word address width (matches memory_subsystem addr)
//  NUM_LINES  8   cache lines, one word each, power of 2, >=2
//  TIMEOUT    32  max cycles in any memory-side state before error abort, >=LATENCY+2
//  PROC_ID    0   requester index, 0..3, used only by the bench and assertions
// PORTS
//  clk              in   1        clock, all logic on posedge
//  reset_n          in   1        synchronous, active-low reset
//  core_req_valid   in   1        core request present
//  core_req_ready   out  1        request accepted when valid&ready
//  core_we          in   1        1=store, 0=load
//  core_addr        in   ADDR_W   word address
//  core_wdata       in   D        store data, D=DATA_SIZE*8
//  core_resp_valid  out  1        one-cycle completion pulse
//  core_rdata       out  D        load data (0 for stores)
//  core_err         out  1        qualifies core_resp_valid: timeout abort
//  mem_proc_req     out  1        to processor_N_req
//  mem_read_req     out  1        read command
//  mem_write_req    out  1        write command
//  mem_addr         out  ADDR_W   memory address
//  mem_write_data   out  D        writeback data
//  mem_grant        in   1        arbiter grant for this requester
//  mem_resp_valid   in   1        read data / write ack valid
//  mem_resp_data    in   D        from processor_N_resp
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): all lines I, FSM IDLE, timeout=0; every output 0 except
//    core_req_ready=1 (ready is set in the first cycle after reset). No writeback of M lines.
//  - index=addr[log2(NUM_LINES)-1:0], tag=remaining upper bits. Hit = state!=I and tag match.
//  - FSM: IDLE, LOOKUP, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, RESP. core_req_ready=1 only in IDLE.
//  - IDLE: on valid&ready, register we/addr/wdata and go to LOOKUP.
//  - LOOKUP: load hit -> RESP with line data. Store hit (S or M) -> write line, state M, RESP.
//    Miss with victim M -> WB_REQ. Miss with victim I/S -> RD_REQ.
//  - Hit latency: accept edge t, core_resp_valid high t+2..t+3 (LOOKUP then RESP).
//  - WB_REQ: proc_req=1, write_req=1, victim addr/data; hold until mem_grant -> WB_WAIT.
//  - WB_WAIT: hold commands; mem_resp_valid (ack) -> victim to I, then RD_REQ.
//  - RD_REQ: proc_req=1, read_req=1, mem_addr=request addr; hold until mem_grant -> RD_WAIT.
//  - RD_WAIT: on mem_resp_valid, fill line. Load: S, core_rdata=mem_resp_data.
//    Store: M, line=core_wdata. Then RESP.
//  - Grant and resp_valid in the same cycle in a *_REQ state: treat as completion and
//    skip the *_WAIT state.
//  - read_req and write_req are never both 1. mem_* are 0 outside WB_*/RD_* states.
//  - Ignore mem_grant/mem_resp_valid in IDLE, LOOKUP and RESP.
//  - Timeout: counter clears on entering WB_REQ and counts every cycle in WB_*/RD_*.
//    At TIMEOUT, go to RESP with core_err=1, core_rdata=0, target line I, mem_* low next cycle.
//  - RESP: one cycle, core_resp_valid=1, then IDLE. Back-to-back requests: 1 idle gap minimum.
// CONFIGURATION
//  SNOOP_INV_EN defined: adds snoop_inv_valid(in,1), snoop_inv_addr(in,ADDR_W),
//    snoop_dirty(out,1). A matching valid line goes to I at that edge.
//    snoop_dirty pulses 1 cycle if the line was M; its data is dropped.
//    A snoop that collides with the same-cycle LOOKUP or fill wins: the core still gets
//    its data, and the line ends I.
//  SNOOP_INV_EN undefined: ports absent; lines leave S/M only via eviction or reset.
// TESTING
//  1 Reset, load 0x0005 -> RD_REQ; grant t+3, resp 0xBEEF t+12 -> rdata=0xBEEF, err=0, line S.
//  2 Repeat load 0x0005 -> core_resp_valid exactly 2 cycles after accept, no mem_proc_req.
//  3 Store 0x0005=0x1234 (hit), then load 0x000D (same index) -> writeback addr 0x0005
//    data 0x1234, then read 0x000D.
//  4 Load 0x0010, never grant -> after 32 cycles core_err=1, rdata=0, mem_* low, next load
//    to 0x0010 misses.
//  5 Grant and resp_valid in the same cycle -> completes, no WAIT cycle, data returned.
//  6 SNOOP_INV_EN: snoop 0x0005 while M -> snoop_dirty pulse, next load 0x0005 misses.

Source files
------------

// File: rtl/proc_mem_requester.sv
// Per-core memory requester: direct-mapped write-back cache (I/S/M lines) in front of memory_subsystem.
// Optional build macro SNOOP_INV_EN adds snoop-invalidate ports (snoop_inv_valid/addr, snoop_dirty).
module proc_mem_requester #(
    parameter int unsigned DATA_SIZE = 2,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned TIMEOUT   = 32,
    parameter int unsigned PROC_ID   = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     core_req_valid,
    output logic                     core_req_ready,
    input  logic                     core_we,
    input  logic [ADDR_W-1:0]        core_addr,
    input  logic [DATA_SIZE*8-1:0]   core_wdata,
    output logic                     core_resp_valid,
    output logic [DATA_SIZE*8-1:0]   core_rdata,
    output logic                     core_err,
    output logic                     mem_proc_req,
    output logic                     mem_read_req,
    output logic                     mem_write_req,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_SIZE*8-1:0]   mem_write_data,
    input  logic                     mem_grant,
    input  logic                     mem_resp_valid,
    input  logic [DATA_SIZE*8-1:0]   mem_resp_data
`ifdef SNOOP_INV_EN
    ,
    input  logic                     snoop_inv_valid,
    input  logic [ADDR_W-1:0]        snoop_inv_addr,
    output logic                     snoop_dirty
`endif
);

    localparam int unsigned DW    = DATA_SIZE * 8;
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, RESP} state_t;
    typedef enum logic [1:0] {LN_I, LN_S, LN_M} line_t;

    state_t             state, state_nxt;
    line_t              line_st   [NUM_LINES];
    logic [TAG_W-1:0]   line_tag  [NUM_LINES];
    logic [DW-1:0]      line_data [NUM_LINES];

    logic               req_we;
    logic [ADDR_W-1:0]  req_addr;
    logic [DW-1:0]      req_wdata;
    logic [DW-1:0]      resp_data;
    logic               resp_err;
    logic [CNT_W-1:0]   tmo_cnt;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit, tmo, wb_done, rd_done, abort;

    assign idx = req_addr[IDX_W-1:0];
    assign tag = req_addr[ADDR_W-1:IDX_W];
    assign hit = (line_st[idx] != LN_I) && (line_tag[idx] == tag);
    assign tmo = (tmo_cnt >= CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // A real completion (grant+resp or resp) outranks the timeout in the same cycle.
    always_comb begin
        state_nxt       = state;
        wb_done         = 1'b0;
        rd_done         = 1'b0;
        abort           = 1'b0;
        core_req_ready  = 1'b0;
        core_resp_valid = 1'b0;
        core_rdata      = '0;
        core_err        = 1'b0;
        mem_proc_req    = 1'b0;
        mem_read_req    = 1'b0;
        mem_write_req   = 1'b0;
        mem_addr        = '0;
        mem_write_data  = '0;
        case (state)
            IDLE: begin
                core_req_ready = 1'b1;
                if (core_req_valid) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (hit)                      state_nxt = RESP;
                else if (line_st[idx] == LN_M) state_nxt = WB_REQ;
                else                          state_nxt = RD_REQ;
            end
            WB_REQ, WB_WAIT: begin
                mem_proc_req   = 1'b1;
                mem_write_req  = 1'b1;
                mem_addr       = {line_tag[idx], idx};
                mem_write_data = line_data[idx];
                if (mem_resp_valid && (state == WB_WAIT || mem_grant)) begin
                    wb_done   = 1'b1;
                    state_nxt = RD_REQ;
                end else if (tmo) begin
                    abort     = 1'b1;
                    state_nxt = RESP;
                end else if (mem_grant) begin
                    state_nxt = WB_WAIT;
                end
            end
            RD_REQ, RD_WAIT: begin
                mem_proc_req = 1'b1;
                mem_read_req = 1'b1;
                mem_addr     = req_addr;
                if (mem_resp_valid && (state == RD_WAIT || mem_grant)) begin
                    rd_done   = 1'b1;
                    state_nxt = RESP;
                end else if (tmo) begin
                    abort     = 1'b1;
                    state_nxt = RESP;
                end else if (mem_grant) begin
                    state_nxt = RD_WAIT;
                end
            end
            RESP: begin
                core_resp_valid = 1'b1;
                core_rdata      = resp_data;
                core_err        = resp_err;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                line_st[i]   <= LN_I;
                line_tag[i]  <= '0;
                line_data[i] <= '0;
            end
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            tmo_cnt   <= '0;
`ifdef SNOOP_INV_EN
            snoop_dirty <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (core_req_valid) begin
                    req_we    <= core_we;
                    req_addr  <= core_addr;
                    req_wdata <= core_wdata;
                end
                LOOKUP: begin
                    tmo_cnt   <= '0;
                    resp_err  <= 1'b0;
                    resp_data <= '0;
                    if (hit) begin
                        if (req_we) begin
                            line_data[idx] <= req_wdata;
                            line_st[idx]   <= LN_M;
                        end else begin
                            resp_data <= line_data[idx];
                        end
                    end
                end
                WB_REQ, WB_WAIT, RD_REQ, RD_WAIT: tmo_cnt <= tmo_cnt + CNT_W'(1);
                default: ;
            endcase
            if (wb_done) line_st[idx] <= LN_I;
            if (rd_done) begin
                line_tag[idx] <= tag;
                if (req_we) begin
                    line_data[idx] <= req_wdata;
                    line_st[idx]   <= LN_M;
                end else begin
                    line_data[idx] <= mem_resp_data;
                    line_st[idx]   <= LN_S;
                    resp_data      <= mem_resp_data;
                end
            end
            if (abort) begin
                line_st[idx] <= LN_I;
                resp_err     <= 1'b1;
                resp_data    <= '0;
            end
`ifdef SNOOP_INV_EN
            // Placed last so a colliding snoop overrides the LOOKUP/fill line update.
            snoop_dirty <= 1'b0;
            if (snoop_inv_valid &&
                line_st[snoop_inv_addr[IDX_W-1:0]] != LN_I &&
                line_tag[snoop_inv_addr[IDX_W-1:0]] == snoop_inv_addr[ADDR_W-1:IDX_W]) begin
                line_st[snoop_inv_addr[IDX_W-1:0]] <= LN_I;
                snoop_dirty <= (line_st[snoop_inv_addr[IDX_W-1:0]] == LN_M);
            end
`endif
            assert (!(mem_read_req && mem_write_req) && PROC_ID < 4);
        end
    end

endmodule
